// File: rtl/tsn_pkg.sv
// Shared types and widths for the per-port TSN metadata path.
package tsn_pkg;

  localparam int NUM_QUEUES = 4;
  localparam int MD_W       = 8;
  localparam int DROP_CNT_W = 16;

  typedef logic [1:0]            qid_t;
  typedef logic [MD_W-1:0]       md_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/md_queue_buffer_if.sv
// Enqueue/dequeue/status bundle between classifier, scheduler, GC and the buffer.
interface md_queue_buffer_if;
    import tsn_pkg::*;

    md_t                    in_mb_md;
    qid_t                   in_mb_qid;
    logic                   in_mb_md_wr;
    logic                   in_mb_q0_rden;
    logic                   in_mb_q1_rden;
    logic                   in_mb_q2_rden;
    logic                   in_mb_q3_rden;
    logic [NUM_QUEUES-1:0]  out_mb_q_nempty;
    logic [NUM_QUEUES-1:0]  out_mb_q_full;
    md_t                    out_mb_md;
    logic                   out_mb_md_wr;
    drop_cnt_t              out_mb_drop_cnt;

    modport master (
        output in_mb_md, in_mb_qid, in_mb_md_wr,
               in_mb_q0_rden, in_mb_q1_rden, in_mb_q2_rden, in_mb_q3_rden,
        input  out_mb_q_nempty, out_mb_q_full, out_mb_md, out_mb_md_wr, out_mb_drop_cnt
    );

    modport slave (
        input  in_mb_md, in_mb_qid, in_mb_md_wr,
               in_mb_q0_rden, in_mb_q1_rden, in_mb_q2_rden, in_mb_q3_rden,
        output out_mb_q_nempty, out_mb_q_full, out_mb_md, out_mb_md_wr, out_mb_drop_cnt
    );

endinterface

// File: rtl/md_fifo.sv
// One circular metadata FIFO: count-based full/empty, registered read data and flags.
module md_fifo
    import tsn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  md_t  wdata_i,
    input  logic pop_i,
    output logic empty_o,
    output logic full_o,
    output logic nempty_reg_o,
    output logic full_reg_o,
    output md_t  rdata_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    md_t           mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          nempty_q, full_q;
    md_t           rdata_q;
    logic          push_ok, pop_ok;

    // Flags come from the pre-update count, so a same-edge pop never frees room for a push.
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
    end

    // NOTE: storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            nempty_q <= 1'b0;
            full_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_q[rd_ptr_q];
            end
            count_q  <= count_d;
            nempty_q <= (count_d != '0);
            full_q   <= (count_d == FULL_CNT);
        end
    end

    assign nempty_reg_o = nempty_q;
    assign full_reg_o   = full_q;
    assign rdata_o      = rdata_q;

endmodule

// File: rtl/md_queue_buffer.sv
// Four priority metadata FIFOs with qid demux, lowest-index pop arbiter and drop counter.
module md_queue_buffer
    import tsn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    md_queue_buffer_if.slave mb
);

    logic [NUM_QUEUES-1:0] rden, push, pop, empty, full, nempty_r, full_r;
    md_t                   rdata [NUM_QUEUES];
    qid_t                  pop_sel;
    logic                  pop_any, drop;

    logic      pop_vld_q;
    qid_t      pop_sel_q;
    md_t       out_md_q;
    logic      out_wr_q;
    drop_cnt_t drop_cnt_q;

    assign rden = {mb.in_mb_q3_rden, mb.in_mb_q2_rden, mb.in_mb_q1_rden, mb.in_mb_q0_rden};

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
        assign push[g] = mb.in_mb_md_wr && (mb.in_mb_qid == qid_t'(g)) && !full[g];

        md_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (push[g]),
            .wdata_i     (mb.in_mb_md),
            .pop_i       (pop[g]),
            .empty_o     (empty[g]),
            .full_o      (full[g]),
            .nempty_reg_o(nempty_r[g]),
            .full_reg_o  (full_r[g]),
            .rdata_o     (rdata[g])
        );
    end

    // Lowest-indexed requesting queue that actually holds data wins.
    always_comb begin
        pop_any = 1'b0;
        pop_sel = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (!pop_any && rden[i] && !empty[i]) begin
                pop_any = 1'b1;
                pop_sel = qid_t'(i);
            end
        end
        pop = pop_any ? (NUM_QUEUES'(1) << pop_sel) : '0;
    end

    assign drop = mb.in_mb_md_wr && full[mb.in_mb_qid];

    // The FIFO registers the popped word; this stage selects it and forms the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_vld_q  <= 1'b0;
            pop_sel_q  <= '0;
            out_md_q   <= '0;
            out_wr_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pop_vld_q <= pop_any;
            pop_sel_q <= pop_sel;
            out_md_q  <= pop_vld_q ? rdata[pop_sel_q] : '0;
            out_wr_q  <= pop_vld_q;
            if (drop)
                drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign mb.out_mb_q_nempty = nempty_r;
    assign mb.out_mb_q_full   = full_r;
    assign mb.out_mb_md       = out_md_q;
    assign mb.out_mb_md_wr    = out_wr_q;
    assign mb.out_mb_drop_cnt = drop_cnt_q;

endmodule

// File: doc/md_queue_buffer.md
# md_queue_buffer

Per-queue metadata buffer between the ingress classifier and the transmit scheduler (ts) on each egress port. It holds 8-bit packet metadata in four priority FIFOs, reports occupancy to gate control (GC), and releases one metadata word per cycle in response to the scheduler's per-queue read enables. Its output feeds ts's metadata input directly.

## Interface
- DEPTH, 16, entries per queue; power of two, 4..256
- AW, 4, log2(DEPTH)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_mb_md  in  8  metadata word to enqueue
- in_mb_qid  in  2  target queue of in_mb_md (0 = highest priority)
- in_mb_md_wr  in  1  enqueue strobe, one word per cycle
- in_mb_q0_rden … in_mb_q3_rden  in  1 each  dequeue requests from ts
- out_mb_q_nempty  out  4  bit n = queue n holds ≥1 entry (to GC)
- out_mb_q_full  out  4  bit n = queue n holds DEPTH entries
- out_mb_md  out  8  dequeued metadata (to ts in_ts_md)
- out_mb_md_wr  out  1  out_mb_md valid strobe
- out_mb_drop_cnt  out  16  enqueue attempts discarded because the target queue was full; saturating

## Operation
- Four independent circular FIFOs, each with wr_ptr and rd_ptr of AW bits and an occupancy count of AW+1 bits (0..DEPTH).
- Enqueue: in_mb_md_wr=1 and count[qid]<DEPTH → write mem[qid][wr_ptr], wr_ptr+1 mod DEPTH, count+1.
- Enqueue to a full queue: word discarded, no pointer change, out_mb_drop_cnt+1 unless at 16'hFFFF (holds).
- Dequeue arbitration: each cycle, among asserted rden bits whose queue is non-empty, the lowest index wins; exactly one pop per cycle maximum. ts may hold several rden bits high simultaneously; lower-indexed queues are always served first.
- rden on an empty queue is ignored (no pop, no strobe, no error); a higher-indexed asserted non-empty queue is then served instead.
- Pop: rd_ptr+1 mod DEPTH, count−1; the popped word is presented with out_mb_md_wr=1.
- Same-cycle enqueue and pop on the same queue: both take effect, count unchanged. On an empty queue the pop is not granted (count evaluated before the write); the word becomes poppable next cycle.
- Same-cycle enqueue to a full queue and pop from it: enqueue still dropped (full evaluated before the pop).
- Pointer wrap-around is modulo DEPTH; full/empty determined by count, never by pointer equality.
- Cycles without a pop: out_mb_md=8'h00, out_mb_md_wr=0.

## Timing
- Reset values: out_mb_md=0, out_mb_md_wr=0, out_mb_q_nempty=0, out_mb_q_full=0, out_mb_drop_cnt=0; all pointers and counts 0. Memory contents not reset.
- Reset asserted mid-operation: all queues empty immediately; no strobe emitted after release until a new enqueue and rden.
- Dequeue latency: rden sampled at edge N → out_mb_md/out_mb_md_wr registered, valid after edge N+1 (one cycle).
- Enqueue-to-visible: write at edge N → out_mb_q_nempty bit set after edge N (registered from updated count); earliest pop on the rden sampled at edge N+1.
- out_mb_q_nempty and out_mb_q_full are registered from post-update counts; they reflect pops and enqueues of the same edge.
- Sustained throughput: one enqueue and one dequeue per cycle.

## Structure
- Shared package tsn_pkg: NUM_QUEUES=4, MD_W=8, queue-id type (2 bits), DROP_CNT_W=16.
- Sub-module md_fifo (one instance per queue): storage, pointers, count, push/pop inputs, empty/full outputs, registered read data. Top level holds the qid demux, lowest-index pop arbiter, output mux/register and drop counter.

## Test plan
- Enqueue 8'hA1, 8'hA2 to q2, rden2 held 3 cycles → out_mb_md A1 then A2 with wr=1, third cycle wr=0; nempty[2] clears after second pop.
- q0 holds 8'h10, q3 holds 8'h30; rden0 and rden3 both high two cycles → 8'h10 then 8'h30.
- Fill q1 with DEPTH words, enqueue 3 more → out_mb_q_full[1]=1, drop_cnt=3, subsequent pops return exactly the first DEPTH words in order.
- Stream 3×DEPTH words through q0 with simultaneous enqueue/pop every cycle → no drops, output order equals input order across wrap.
- Enqueue to empty q2 and rden2 in the same cycle → no strobe that cycle; word appears one cycle after the next rden2.
- Load q0..q3, assert rst_n low for one cycle mid-stream → all outputs 0, nempty=0, rden afterwards produces no strobe.
